// File: rtl/dispatch_hazard_ctrl_if.sv
// Dispatch-to-execute hazard controller bundle: dispatch request, execute
// handshake, writeback retire, and the controller's issue/status outputs.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

interface dispatch_hazard_ctrl_if;
  logic                        inst_valid_i;
  logic [`REG_ADDR_WIDTH-1:0]  reg1_raddr_i;
  logic [`REG_ADDR_WIDTH-1:0]  reg2_raddr_i;
  logic                        rs1_re_i;
  logic                        rs2_re_i;
  logic [`REG_ADDR_WIDTH-1:0]  reg_waddr_i;
  logic                        reg_we_i;
  logic [`INST_ADDR_WIDTH-1:0] dec_pc_i;
  logic                        ex_ready_i;
  logic                        wb_we_i;
  logic [`REG_ADDR_WIDTH-1:0]  wb_waddr_i;
  logic                        flush_i;
  logic                        stall_o;
  logic                        ex_valid_o;
  logic [`REG_ADDR_WIDTH-1:0]  ex_rd_o;
  logic                        ex_rd_we_o;
  logic [`INST_ADDR_WIDTH-1:0] ex_pc_o;
  logic [31:0]                 busy_o;
  logic [31:0]                 stall_cnt_o;
  logic                        wb_err_o;

  modport slave (
    input  inst_valid_i, reg1_raddr_i, reg2_raddr_i, rs1_re_i, rs2_re_i,
           reg_waddr_i, reg_we_i, dec_pc_i, ex_ready_i, wb_we_i, wb_waddr_i, flush_i,
    output stall_o, ex_valid_o, ex_rd_o, ex_rd_we_o, ex_pc_o, busy_o, stall_cnt_o, wb_err_o
  );

  modport master (
    output inst_valid_i, reg1_raddr_i, reg2_raddr_i, rs1_re_i, rs2_re_i,
           reg_waddr_i, reg_we_i, dec_pc_i, ex_ready_i, wb_we_i, wb_waddr_i, flush_i,
    input  stall_o, ex_valid_o, ex_rd_o, ex_rd_we_o, ex_pc_o, busy_o, stall_cnt_o, wb_err_o
  );
endinterface

// File: rtl/dispatch_hazard_ctrl.sv
// Scoreboard-based dispatch hazard control: RAW/WAW stall with same-cycle
// writeback bypass, in-flight writer limit, registered issue to execute.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module dispatch_hazard_ctrl #(
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  dispatch_hazard_ctrl_if.slave   bus
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;
  localparam int NREG  = 32;
  localparam int AW    = `REG_ADDR_WIDTH;
  localparam int PW    = `INST_ADDR_WIDTH;

  logic [NREG-1:0]  busy_q, busy_d, busy_eff, set_vec, clr_vec;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             wb_err_q, wb_err_d;
  logic             ex_valid_q, ex_valid_d;
  logic             ex_rd_we_q, ex_rd_we_d;
  logic [AW-1:0]    ex_rd_q, ex_rd_d;
  logic [PW-1:0]    ex_pc_q, ex_pc_d;
  logic             raw, waw, full, issue, stall, set_en, clr_en;

  // Register 0 is hardwired: never busy, never hazards.
  assign busy_eff[0] = 1'b0;
  assign busy_d[0]   = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
      assign busy_eff[gi] = busy_q[gi] & ~clr_vec[gi];
      assign busy_d[gi]   = set_vec[gi] | (busy_q[gi] & ~clr_vec[gi]);
    end
  endgenerate

  always_comb begin
    clr_en  = bus.wb_we_i && (bus.wb_waddr_i != '0);
    clr_vec = clr_en ? (NREG'(1) << bus.wb_waddr_i) : '0;

    raw   = (bus.rs1_re_i && busy_eff[bus.reg1_raddr_i]) ||
            (bus.rs2_re_i && busy_eff[bus.reg2_raddr_i]);
    waw   = bus.reg_we_i && busy_eff[bus.reg_waddr_i];
    full  = bus.reg_we_i && (inflight_q == CNT_W'(MAX_INFLIGHT));
    issue = bus.inst_valid_i && !bus.flush_i && bus.ex_ready_i && !raw && !waw && !full;
    stall = bus.inst_valid_i && !bus.flush_i && !issue;

    set_en  = issue && bus.reg_we_i && (bus.reg_waddr_i != '0);
    set_vec = set_en ? (NREG'(1) << bus.reg_waddr_i) : '0;
  end

  // Simultaneous retire and new writer cancel out in the in-flight count.
  always_comb begin
    inflight_d = inflight_q;
    wb_err_d   = wb_err_q;
    if (set_en && !clr_en) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (clr_en && !set_en) begin
      if (inflight_q == '0) begin
        wb_err_d = 1'b1;
      end else begin
        inflight_d = inflight_q - CNT_W'(1);
      end
    end
    stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    ex_valid_d  = issue;
    ex_rd_we_d  = issue && bus.reg_we_i;
    ex_rd_d     = bus.reg_waddr_i;
    ex_pc_d     = bus.dec_pc_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      inflight_q  <= '0;
      stall_cnt_q <= '0;
      wb_err_q    <= 1'b0;
      ex_valid_q  <= 1'b0;
      ex_rd_we_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_pc_q     <= '0;
    end else begin
      busy_q      <= busy_d;
      inflight_q  <= inflight_d;
      stall_cnt_q <= stall_cnt_d;
      wb_err_q    <= wb_err_d;
      ex_valid_q  <= ex_valid_d;
      ex_rd_we_q  <= ex_rd_we_d;
      ex_rd_q     <= ex_rd_d;
      ex_pc_q     <= ex_pc_d;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.ex_valid_o  = ex_valid_q;
  assign bus.ex_rd_o     = ex_rd_q;
  assign bus.ex_rd_we_o  = ex_rd_we_q;
  assign bus.ex_pc_o     = ex_pc_q;
  assign bus.busy_o      = busy_q;
  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.wb_err_o    = wb_err_q;
endmodule
